// File: rtl/anchor_sequencer.sv
// Anchor-step sequencer for the edge-detection pipeline: walks an anchor over
// COLS x ROWS positions and waits for every filter stage and the output buffer.
module anchor_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int COLS       = 64,
  parameter int ROWS       = 48,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_final,
  input  logic                  out_ready,
  output logic                  anchor_moving,
  output logic [9:0]            anchor_x,
  output logic [9:0]            anchor_y,
  output logic                  busy,
  output logic                  image_done,
  output logic                  timeout_err
);

  localparam logic [9:0] LAST_X      = 10'(COLS - 1);
  localparam logic [9:0] LAST_Y      = 10'(ROWS - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [9:0] anchor_x_reg, anchor_x_next;
  logic [9:0] anchor_y_reg, anchor_y_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       timeout_err_reg, timeout_err_next;
  logic       step_ready;

  assign step_ready = (&stage_final) && out_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= S_IDLE;
      anchor_x_reg    <= '0;
      anchor_y_reg    <= '0;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      anchor_x_reg    <= anchor_x_next;
      anchor_y_reg    <= anchor_y_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    anchor_x_next    = anchor_x_reg;
    anchor_y_next    = anchor_y_reg;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = timeout_err_reg;
    // Abort wins over everything once a pass is running; position and error hold.
    if (abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && !abort) begin
            anchor_x_next    = '0;
            anchor_y_next    = '0;
            timeout_err_next = 1'b0;
            state_next       = S_ISSUE;
          end
        end
        S_ISSUE:  state_next = S_SETTLE;
        S_SETTLE: begin
          // Completion flags here still belong to the previous step.
          wait_cnt_next = '0;
          state_next    = S_WAIT;
        end
        S_WAIT: begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (step_ready) begin
            state_next = S_ADVANCE;
          end else if (wait_cnt_reg == TIMEOUT_CNT) begin
            timeout_err_next = 1'b1;
            state_next       = S_IDLE;
          end
        end
        S_ADVANCE: begin
          if (anchor_x_reg < LAST_X) begin
            anchor_x_next = anchor_x_reg + 10'd1;
            state_next    = S_ISSUE;
          end else if (anchor_y_reg < LAST_Y) begin
            anchor_x_next = '0;
            anchor_y_next = anchor_y_reg + 10'd1;
            state_next    = S_ISSUE;
          end else begin
            state_next = S_DONE;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign anchor_moving = (state_reg == S_ISSUE);
  assign image_done    = (state_reg == S_DONE);
  assign busy          = (state_reg != S_IDLE);
  assign anchor_x      = anchor_x_reg;
  assign anchor_y      = anchor_y_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: doc/anchor_sequencer.md
ANCHOR_SEQUENCER -- requirements
Module: anchor_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4, number of filter-stage controllers sequenced (gaussian, sobel, nms, hyst).
REQ-002 Parameter COLS, default 64, anchor steps per row; legal range 2..1024.
REQ-003 Parameter ROWS, default 48, anchor rows per image; legal range 2..1024.
REQ-004 Parameter TIMEOUT, default 255, maximum stage-wait cycles per anchor step; legal range 1..255.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  level; begin an image pass when sampled high in IDLE.
REQ-008 abort  input  1  level; synchronous abandonment of the current pass.
REQ-009 stage_final  input  NUM_STAGES  per-stage completion flags; high = stage finished its current anchor step.
REQ-010 out_ready  input  1  downstream output buffer can accept one anchor step of results.
REQ-011 anchor_moving  output  1  one-cycle pulse telling every stage controller to load fresh data.
REQ-012 anchor_x  output  10  current anchor column index.
REQ-013 anchor_y  output  10  current anchor row index.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 image_done  output  1  one-cycle pulse when the final anchor step completes.
REQ-016 timeout_err  output  1  sticky stage-wait timeout flag.

Function
REQ-017 States are IDLE, ISSUE, SETTLE, WAIT, ADVANCE and DONE.
REQ-018 IDLE with start=1 clears anchor_x, anchor_y and timeout_err, then goes to ISSUE; IDLE otherwise holds.
REQ-019 ISSUE drives anchor_moving=1 for exactly that cycle and always goes to SETTLE.
REQ-020 SETTLE ignores stage_final (stale flags from the previous step), clears the wait counter and always goes to WAIT.
REQ-021 WAIT increments an 8-bit wait counter each cycle; when stage_final is all ones and out_ready=1 in the same cycle, it goes to ADVANCE.
REQ-022 WAIT with a counter value equal to TIMEOUT and the exit condition still false sets timeout_err and goes to IDLE.
REQ-023 WAIT with the exit condition true in the same cycle the counter reaches TIMEOUT goes to ADVANCE; the exit condition takes priority and timeout_err is not set.
REQ-024 ADVANCE updates the position as follows:
  - anchor_x < COLS-1: anchor_x+1, then ISSUE.
  - anchor_x = COLS-1 and anchor_y < ROWS-1: anchor_x=0, anchor_y+1, then ISSUE.
  - anchor_x = COLS-1 and anchor_y = ROWS-1: position unchanged, then DONE.
REQ-025 DONE drives image_done=1 for that cycle and goes to IDLE; anchor_x and anchor_y hold their final values until the next start.
REQ-026 abort=1 in any non-IDLE state forces IDLE on the next edge; abort outranks every other transition; no anchor_moving or image_done pulse is generated in that cycle; anchor_x, anchor_y and timeout_err hold.
REQ-027 abort=1 in IDLE is ignored; start in that cycle is also ignored.
REQ-028 start while busy=1 is ignored.
REQ-029 anchor_moving, image_done and busy are registered or decoded directly from the state register; they never depend combinationally on inputs.
REQ-030 timeout_err clears only on reset or on an accepted start.
REQ-031 Minimum per-step latency is 4 cycles (ISSUE, SETTLE, WAIT, ADVANCE), so anchor_moving pulses are at least 4 cycles apart.

Reset
REQ-032 n_rst=0 asynchronously forces state IDLE, anchor_x=0, anchor_y=0, wait counter=0, anchor_moving=0, busy=0, image_done=0, timeout_err=0.
REQ-033 Reset asserted mid-pass takes effect immediately; no further anchor_moving pulse is issued after reset is released until a new start.

Verification
REQ-034 Full pass, COLS=2, ROWS=2, stage_final and out_ready tied high after SETTLE: start → 4 anchor_moving pulses at positions (0,0),(1,0),(0,1),(1,1), 4 cycles apart; image_done pulses once, 1 cycle after the final ADVANCE.
REQ-035 Stale flag: stage_final held all ones throughout: sequencer still spends exactly one cycle in SETTLE before WAIT and does not skip a step.
REQ-036 Back-pressure: all stages final, out_ready low for 10 cycles, then high → ADVANCE on the first cycle with out_ready=1; timeout_err stays 0 (TIMEOUT=255).
REQ-037 Timeout: TIMEOUT=5, one stage_final bit held low → timeout_err=1 and busy=0 after the 6th WAIT cycle; the next start clears timeout_err.
REQ-038 Abort in WAIT at position (1,0) → IDLE next cycle; no image_done; anchor_x=1, anchor_y=0 retained.
REQ-039 Async reset during ISSUE → outputs at reset values before the next clock edge; start ignored while n_rst=0.
